// File: rtl/bcd_display_scan.sv
// bcd_display_scan: captures a packed BCD word and scans it onto one
// 7-segment bus with rotating one-hot digit enables. Each digit is shown
// for REFRESH_DIV cycles. Leading zeros can be blanked, and non-BCD codes
// are shown as a dash.
module bcd_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] held_q, held_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic [3:0] cur_digit;
  logic       upper_zero;
  logic       blank;

  // Segment pattern {g,f,e,d,c,b,a}; any code above 9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Capture register: load replaces the held word, otherwise it holds.
  always_comb begin
    held_d = held_q;
    if (load) held_d = bcd_in;
  end

  // Dwell divider and digit index; index only moves when the divider wraps.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the current digit and decide whether it is a leading zero.
  // Invalid codes are nonzero, so they terminate blanking naturally.
  always_comb begin
    cur_digit  = 4'd0;
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) cur_digit = held_q[4*k +: 4];
      if ((k >= int'(idx_q)) && (held_q[4*k +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    blank = blank_lz && (idx_q != '0) && upper_zero;
  end

  // Output staging: one-hot enable and segment pattern from pre-edge state.
  always_comb begin
    an_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = (idx_q == IDX_W'(k));
    end
    seg_d = blank ? 7'h00 : seg_decode(cur_digit);
  end

  // All state registers; reset wins over load and over scanning.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q    <= '0;
      div_cnt_q <= '0;
      idx_q     <= '0;
      an_q      <= '0;
      seg_q     <= '0;
    end else begin
      held_q    <= held_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Testbench for bcd_display_scan: a table of loaded words with expected
// per-digit segment patterns, plus hand-written reset/load/blank sequences.
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_vec  = 0;
  int n_fail = 0;

  bcd_display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     bcd;
    logic            blz;
    logic [3:0][6:0] exp_seg;  // index = digit number
  } vec_t;

  vec_t vecs [9];

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    n_vec++;
    if (an !== exp_an || seg !== exp_seg) begin
      n_fail++;
      $display("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", name, an, seg, exp_an, exp_seg);
    end
  endtask

  // Reset, release with a load of v.bcd, then walk a full scan plus the wrap.
  task automatic run_vec(input int vi, input vec_t v);
    int d;
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0;
    step();
    reset = 1'b0; load = 1'b1; bcd_in = v.bcd; blank_lz = v.blz;
    step();
    check($sformatf("vec%0d_edge1", vi), 4'b0001, 7'h3F);
    load = 1'b0;
    for (int e = 2; e <= 17; e++) begin
      step();
      d = ((e - 1) / 4) % 4;
      check($sformatf("vec%0d_edge%0d", vi, e), 4'(1 << d), v.exp_seg[d]);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; bcd_in = '0; blank_lz = 1'b0;

    vecs[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'h0070, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3F}};
    vecs[2] = '{16'h0070, 1'b0, {7'h3F, 7'h3F, 7'h07, 7'h3F}};
    vecs[3] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[4] = '{16'h00A5, 1'b1, {7'h00, 7'h00, 7'h40, 7'h6D}};
    vecs[5] = '{16'h5678, 1'b0, {7'h6D, 7'h7D, 7'h07, 7'h7F}};
    vecs[6] = '{16'h9F00, 1'b1, {7'h6F, 7'h40, 7'h3F, 7'h3F}};
    vecs[7] = '{16'h0900, 1'b1, {7'h00, 7'h6F, 7'h3F, 7'h3F}};
    vecs[8] = '{16'h8000, 1'b1, {7'h7F, 7'h3F, 7'h3F, 7'h3F}};

    // Reset held for two edges, then the first dwell of digit 0.
    step();
    check("reset_edge1", 4'b0000, 7'h00);
    step();
    check("reset_edge2", 4'b0000, 7'h00);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("release_edge%0d", e), 4'b0001, 7'h3F);
    end
    step();
    check("release_edge5", 4'b0010, 7'h3F);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // blank_lz takes effect one edge after it changes.
    reset = 1'b1; step();
    reset = 1'b0; load = 1'b1; bcd_in = 16'h0070; blank_lz = 1'b1;
    step();
    load = 1'b0;
    for (int e = 2; e <= 13; e++) step();
    check("blank_on_d3", 4'b1000, 7'h00);
    blank_lz = 1'b0;
    step();
    check("blank_off_d3", 4'b1000, 7'h3F);

    // Load during the second cycle of digit 0; dwell timing unchanged.
    reset = 1'b1; blank_lz = 1'b0; step();
    reset = 1'b0;
    step();
    check("midload_edge1", 4'b0001, 7'h3F);
    load = 1'b1; bcd_in = 16'h0009;
    step();
    check("midload_edge2", 4'b0001, 7'h3F);
    load = 1'b0;
    step();
    check("midload_edge3", 4'b0001, 7'h6F);
    step();
    check("midload_edge4", 4'b0001, 7'h6F);
    step();
    check("midload_edge5", 4'b0010, 7'h3F);

    // Back-to-back loads: the last one wins.
    load = 1'b1; bcd_in = 16'h3333;
    step();
    bcd_in = 16'h4444;
    step();
    load = 1'b0;
    step();
    check("b2b_load", 4'b0010, 7'h66);

    // Reset while digit 2 is lit, then a clean restart with held cleared.
    reset = 1'b1; step();
    reset = 1'b0; load = 1'b1; bcd_in = 16'h1234;
    step();
    load = 1'b0;
    for (int e = 2; e <= 9; e++) step();
    check("midscan_pre", 4'b0100, 7'h5B);
    reset = 1'b1;
    step();
    check("midscan_reset", 4'b0000, 7'h00);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("midscan_restart%0d", e), 4'b0001, 7'h3F);
    end
    step();
    check("midscan_restart5", 4'b0010, 7'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
